fir_controller_param: RTL and testbench

- Parametrised control unit for the FIR filter datapath; drives the shared register-file/ALU datapath through op/src1/src2/dest each cycle.
- Successor to the fixed 4-tap controller. Generalised to NUM_TAPS taps, with a per-tap add/subtract sign mask and a one-cycle done pulse.
- Sits between the host handshake (dr, lc), the sample counter (cnt_up, clear) and the datapath (overflow in, op/src/dest out).

---
 rtl/fir_controller_param.sv | 137 +++++++++++++
 tb/tb_fir_controller_param.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fir_controller_param.sv
// fir_controller_param: Moore FSM sequencing the shared FIR datapath over NUM_TAPS taps.
module fir_controller_param #(
  parameter int NUM_TAPS = 4,
  parameter int REG_ADDR_W = 4,
  parameter logic [NUM_TAPS-1:0] SIGN_MASK = 4'b1010
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  dr,
  input  logic                  lc,
  input  logic                  overflow,
  output logic                  cnt_up,
  output logic                  clear,
  output logic                  modwait,
  output logic [2:0]            op,
  output logic [REG_ADDR_W-1:0] src1,
  output logic [REG_ADDR_W-1:0] src2,
  output logic [REG_ADDR_W-1:0] dest,
  output logic                  err,
  output logic                  done
);
  localparam logic [3:0] S_IDLE = 4'd0, S_STORE = 4'd1, S_ZERO = 4'd2, S_SHIFT = 4'd3,
                         S_SHIFTIN = 4'd4, S_MUL = 4'd5, S_ACC = 4'd6, S_DONE = 4'd7,
                         S_EIDLE = 4'd8, S_LOADC = 4'd9, S_WAITC = 4'd10;
  localparam logic [2:0] OP_NOP = 3'b000, OP_COPY = 3'b001, OP_LOAD1 = 3'b010,
                         OP_LOAD2 = 3'b011, OP_ADD = 3'b100, OP_SUB = 3'b101, OP_MUL = 3'b110;
  localparam logic [REG_ADDR_W-1:0] NONE = '1, R0 = '0, ONE = REG_ADDR_W'(1),
                                    CB = REG_ADDR_W'(NUM_TAPS + 1),
                                    RS = REG_ADDR_W'(2 * NUM_TAPS + 1),
                                    RT = REG_ADDR_W'(2 * NUM_TAPS + 2);
  localparam logic [2:0] KMAX = 3'(NUM_TAPS - 1);
  logic [3:0] state, nxt;
  logic [2:0] k, k_nxt;
  logic [REG_ADDR_W-1:0] ka;
  logic [7:0] mask;
  assign ka = REG_ADDR_W'(k);
  assign mask = 8'(SIGN_MASK);
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= S_IDLE;
      k <= '0;
    end else begin
      state <= nxt;
      k <= k_nxt;
    end
  always_comb begin
    nxt = state;
    k_nxt = k;
    case (state)
      S_IDLE, S_EIDLE:
        if (dr) nxt = S_STORE;
        else if (lc) begin
          nxt = S_LOADC;
          k_nxt = '0;
        end
      S_STORE: nxt = dr ? S_ZERO : S_EIDLE;
      S_ZERO: begin
        nxt = S_SHIFT;
        k_nxt = KMAX;
      end
      S_SHIFT:
        if (k > 3'd1) k_nxt = k - 3'd1;
        else nxt = S_SHIFTIN;
      S_SHIFTIN: begin
        nxt = S_MUL;
        k_nxt = '0;
      end
      S_MUL: nxt = S_ACC;
      S_ACC:
        if (overflow) nxt = S_EIDLE;
        else if (k < KMAX) begin
          nxt = S_MUL;
          k_nxt = k + 3'd1;
        end else nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      S_LOADC: nxt = S_WAITC;
      S_WAITC:
        if (k == KMAX) nxt = S_IDLE;
        else if (lc) begin
          nxt = S_LOADC;
          k_nxt = k + 3'd1;
        end
      default: nxt = S_IDLE;
    endcase
  end
  assign modwait = !(state == S_IDLE || state == S_EIDLE || state == S_WAITC);
  assign cnt_up = state == S_STORE;
  assign clear = state == S_LOADC && k == 3'd0;
  assign err = state == S_EIDLE;
  assign done = state == S_DONE;
  // Sample history S[k] lives at R(1+k), so S[k-1] is simply R(k).
  always_comb begin
    op = OP_NOP;
    src1 = NONE;
    src2 = NONE;
    dest = NONE;
    case (state)
      S_STORE: begin
        op = OP_LOAD1;
        dest = RS;
      end
      S_ZERO: begin
        op = OP_SUB;
        src1 = R0;
        src2 = R0;
        dest = R0;
      end
      S_SHIFT: begin
        op = OP_COPY;
        src1 = ka;
        dest = ka + ONE;
      end
      S_SHIFTIN: begin
        op = OP_COPY;
        src1 = RS;
        dest = ONE;
      end
      S_MUL: begin
        op = OP_MUL;
        src1 = ka + ONE;
        src2 = CB + ka;
        dest = RT;
      end
      S_ACC: begin
        op = mask[k] ? OP_SUB : OP_ADD;
        src1 = R0;
        src2 = RT;
        dest = R0;
      end
      S_LOADC: begin
        op = OP_LOAD2;
        dest = CB + ka;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fir_controller_param.sv
// tb_fir_controller_param: directed checks of the 4-tap and 6-tap controller builds.
module tb_fir_controller_param;
  logic clk = 0, n_rst = 0, dr = 0, lc = 0, overflow = 0;
  logic cnt_up4, clear4, modwait4, err4, done4, cnt_up6, clear6, modwait6, err6, done6;
  logic [2:0] op4, op6;
  logic [3:0] src1_4, src2_4, dest4, src1_6, src2_6, dest6;
  logic [19:0] obs4, obs6, exp4 [15], exp6 [21];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fir_controller_param dut4 (
    .clk(clk), .n_rst(n_rst), .dr(dr), .lc(lc), .overflow(overflow),
    .cnt_up(cnt_up4), .clear(clear4), .modwait(modwait4), .op(op4),
    .src1(src1_4), .src2(src2_4), .dest(dest4), .err(err4), .done(done4));
  fir_controller_param #(.NUM_TAPS(6), .REG_ADDR_W(4), .SIGN_MASK(6'b100110)) dut6 (
    .clk(clk), .n_rst(n_rst), .dr(dr), .lc(lc), .overflow(overflow),
    .cnt_up(cnt_up6), .clear(clear6), .modwait(modwait6), .op(op6),
    .src1(src1_6), .src2(src2_6), .dest(dest6), .err(err6), .done(done6));
  assign obs4 = {modwait4, op4, src1_4, src2_4, dest4, cnt_up4, clear4, err4, done4};
  assign obs6 = {modwait6, op6, src1_6, src2_6, dest6, cnt_up6, clear6, err6, done6};
  // Flags argument packs {cnt_up, clear, err, done}.
  function automatic logic [19:0] ex(input logic mw, input logic [2:0] o,
                                     input logic [3:0] s1, s2, d, input logic [3:0] fl);
    return {mw, o, s1, s2, d, fl};
  endfunction
  localparam logic [19:0] IDLEV = {1'b0, 3'd0, 4'd15, 4'd15, 4'd15, 4'b0000};
  localparam logic [19:0] EIDLEV = {1'b0, 3'd0, 4'd15, 4'd15, 4'd15, 4'b0010};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    n_rst = 0;
    dr = 0;
    lc = 0;
    overflow = 0;
    tick;
    n_rst = 1;
  endtask
  task automatic test_reset;
    #2;
    checks++;
    if (obs4 !== IDLEV) begin errors++; $display("FAIL reset4 got %h want %h", obs4, IDLEV); end
    checks++;
    if (obs6 !== IDLEV) begin errors++; $display("FAIL reset6 got %h want %h", obs6, IDLEV); end
    do_reset;
    checks++;
    if (obs4 !== IDLEV) begin errors++; $display("FAIL idle4 got %h want %h", obs4, IDLEV); end
  endtask
  task automatic test_short_dr;
    do_reset;
    dr = 1;
    tick;
    dr = 0;
    checks++;
    if (obs4 !== exp4[0]) begin errors++; $display("FAIL short_store got %h want %h", obs4, exp4[0]); end
    tick;
    checks++;
    if (obs4 !== EIDLEV) begin errors++; $display("FAIL short_eidle got %h want %h", obs4, EIDLEV); end
  endtask
  task automatic run4(input string name);
    dr = 1;
    tick;
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (obs4 !== exp4[i]) begin errors++; $display("FAIL %s step %0d got %h want %h", name, i, obs4, exp4[i]); end
      if (i == 1) dr = 0;
      tick;
    end
    checks++;
    if (obs4 !== IDLEV) begin errors++; $display("FAIL %s end got %h want %h", name, obs4, IDLEV); end
  endtask
  task automatic test_full;
    do_reset;
    run4("full4");
  endtask
  task automatic test_overflow;
    do_reset;
    dr = 1;
    tick;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (obs4 !== exp4[i]) begin errors++; $display("FAIL ovf step %0d got %h want %h", i, obs4, exp4[i]); end
      if (i == 1) dr = 0;
      if (i == 10) overflow = 1;
      if (i < 11) tick;
    end
    tick;
    overflow = 0;
    checks++;
    if (obs4 !== EIDLEV) begin errors++; $display("FAIL ovf_eidle got %h want %h", obs4, EIDLEV); end
    run4("recover");
  endtask
  task automatic test_load_coef;
    logic [19:0] want [10];
    want[0] = ex(1, 3'd3, 15, 15, 5, 4'b0100);
    want[1] = ex(0, 3'd0, 15, 15, 15, 4'b0000);
    want[2] = ex(0, 3'd0, 15, 15, 15, 4'b0000);
    want[3] = ex(1, 3'd3, 15, 15, 6, 4'b0000);
    want[4] = ex(0, 3'd0, 15, 15, 15, 4'b0000);
    want[5] = ex(1, 3'd3, 15, 15, 7, 4'b0000);
    want[6] = ex(0, 3'd0, 15, 15, 15, 4'b0000);
    want[7] = ex(1, 3'd3, 15, 15, 8, 4'b0000);
    want[8] = ex(0, 3'd0, 15, 15, 15, 4'b0000);
    want[9] = IDLEV;
    do_reset;
    lc = 1;
    tick;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs4 !== want[i]) begin errors++; $display("FAIL loadc step %0d got %h want %h", i, obs4, want[i]); end
      lc = (i != 1 && i < 8);
      dr = (i == 1);
      tick;
    end
    dr = 0;
    lc = 0;
  endtask
  task automatic test_six_taps;
    do_reset;
    dr = 1;
    tick;
    for (int i = 0; i < 21; i++) begin
      checks++;
      if (obs6 !== exp6[i]) begin errors++; $display("FAIL six step %0d got %h want %h", i, obs6, exp6[i]); end
      if (i == 1) dr = 0;
      tick;
    end
    checks++;
    if (obs6 !== IDLEV) begin errors++; $display("FAIL six_end got %h want %h", obs6, IDLEV); end
    dr = 1;
    tick;
    tick;
    dr = 0;
    for (int i = 2; i < 9; i++) tick;
    checks++;
    if (obs6 !== exp6[8]) begin errors++; $display("FAIL six_mul0 got %h want %h", obs6, exp6[8]); end
    #2 n_rst = 0;
    #1;
    checks++;
    if (obs6 !== IDLEV) begin errors++; $display("FAIL async_rst6 got %h want %h", obs6, IDLEV); end
    checks++;
    if (obs4 !== IDLEV) begin errors++; $display("FAIL async_rst4 got %h want %h", obs4, IDLEV); end
    tick;
    n_rst = 1;
  endtask
  initial begin
    exp4[0] = ex(1, 3'd2, 15, 15, 9, 4'b1000);
    exp4[1] = ex(1, 3'd5, 0, 0, 0, 4'b0000);
    exp4[2] = ex(1, 3'd1, 3, 15, 4, 4'b0000);
    exp4[3] = ex(1, 3'd1, 2, 15, 3, 4'b0000);
    exp4[4] = ex(1, 3'd1, 1, 15, 2, 4'b0000);
    exp4[5] = ex(1, 3'd1, 9, 15, 1, 4'b0000);
    exp4[6] = ex(1, 3'd6, 1, 5, 10, 4'b0000);
    exp4[7] = ex(1, 3'd4, 0, 10, 0, 4'b0000);
    exp4[8] = ex(1, 3'd6, 2, 6, 10, 4'b0000);
    exp4[9] = ex(1, 3'd5, 0, 10, 0, 4'b0000);
    exp4[10] = ex(1, 3'd6, 3, 7, 10, 4'b0000);
    exp4[11] = ex(1, 3'd4, 0, 10, 0, 4'b0000);
    exp4[12] = ex(1, 3'd6, 4, 8, 10, 4'b0000);
    exp4[13] = ex(1, 3'd5, 0, 10, 0, 4'b0000);
    exp4[14] = ex(1, 3'd0, 15, 15, 15, 4'b0001);
    exp6[0] = ex(1, 3'd2, 15, 15, 13, 4'b1000);
    exp6[1] = ex(1, 3'd5, 0, 0, 0, 4'b0000);
    exp6[2] = ex(1, 3'd1, 5, 15, 6, 4'b0000);
    exp6[3] = ex(1, 3'd1, 4, 15, 5, 4'b0000);
    exp6[4] = ex(1, 3'd1, 3, 15, 4, 4'b0000);
    exp6[5] = ex(1, 3'd1, 2, 15, 3, 4'b0000);
    exp6[6] = ex(1, 3'd1, 1, 15, 2, 4'b0000);
    exp6[7] = ex(1, 3'd1, 13, 15, 1, 4'b0000);
    exp6[8] = ex(1, 3'd6, 1, 7, 14, 4'b0000);
    exp6[9] = ex(1, 3'd4, 0, 14, 0, 4'b0000);
    exp6[10] = ex(1, 3'd6, 2, 8, 14, 4'b0000);
    exp6[11] = ex(1, 3'd5, 0, 14, 0, 4'b0000);
    exp6[12] = ex(1, 3'd6, 3, 9, 14, 4'b0000);
    exp6[13] = ex(1, 3'd5, 0, 14, 0, 4'b0000);
    exp6[14] = ex(1, 3'd6, 4, 10, 14, 4'b0000);
    exp6[15] = ex(1, 3'd4, 0, 14, 0, 4'b0000);
    exp6[16] = ex(1, 3'd6, 5, 11, 14, 4'b0000);
    exp6[17] = ex(1, 3'd4, 0, 14, 0, 4'b0000);
    exp6[18] = ex(1, 3'd6, 6, 12, 14, 4'b0000);
    exp6[19] = ex(1, 3'd5, 0, 14, 0, 4'b0000);
    exp6[20] = ex(1, 3'd0, 15, 15, 15, 4'b0001);
    test_reset;
    test_short_dr;
    test_full;
    test_overflow;
    test_load_coef;
    test_six_taps;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
